// File: rtl/id_ex_hazard_if.sv
// ID->EX stage bundle: decoded instruction fields in, latched EX fields and hazard controls out.
// The fetch/decode side drives through master; the pipeline register takes the slave view.
interface id_ex_hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_RSaddr, ID_RTaddr, ID_RDaddr;
  logic             ID_UseRT;
  logic [31:0]      ID_RSdata, ID_RTdata, ID_Imm;
  logic             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
  logic [2:0]       ID_ALUOp;
  logic             Flush;

  logic [4:0]       EX_RSaddr, EX_RTaddr, EX_WRaddr;
  logic [31:0]      EX_RSdata, EX_RTdata, EX_Imm;
  logic             EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc;
  logic [2:0]       EX_ALUOp;
  logic             EX_Valid;
  logic             PC_Write, IFID_Write, Stall;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output ID_RSaddr, ID_RTaddr, ID_RDaddr, ID_UseRT, ID_RSdata, ID_RTdata, ID_Imm,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst,
           ID_ALUOp, Flush,
    input  EX_RSaddr, EX_RTaddr, EX_WRaddr, EX_RSdata, EX_RTdata, EX_Imm,
           EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_ALUOp,
           EX_Valid, PC_Write, IFID_Write, Stall, StallCnt
  );

  modport slave (
    input  ID_RSaddr, ID_RTaddr, ID_RDaddr, ID_UseRT, ID_RSdata, ID_RTdata, ID_Imm,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst,
           ID_ALUOp, Flush,
    output EX_RSaddr, EX_RTaddr, EX_WRaddr, EX_RSdata, EX_RTdata, EX_Imm,
           EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_ALUOp,
           EX_Valid, PC_Write, IFID_Write, Stall, StallCnt
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall detection, flush-to-bubble and a saturating stall counter.
// One cycle ID->EX; Stall/PC_Write/IFID_Write are combinational from EX state and ID inputs.
module id_ex_hazard_reg #(
  parameter int CNT_W = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  id_ex_hazard_if.slave bus
);
  logic [4:0]       r_rs_addr, r_rt_addr, r_wr_addr;
  logic [31:0]      r_rs_data, r_rt_data, r_imm;
  logic             r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src;
  logic [2:0]       r_alu_op;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs_hit, w_rt_hit, w_stall, w_bubble, w_cnt_max;

  // A load into $0 never produces data anyone waits for, so it cannot stall.
  assign w_rs_hit  = (r_wr_addr == bus.ID_RSaddr);
  assign w_rt_hit  = bus.ID_UseRT && (r_wr_addr == bus.ID_RTaddr);
  assign w_stall   = r_mem_read && r_valid && (r_wr_addr != 5'd0) && (w_rs_hit || w_rt_hit);
  assign w_bubble  = bus.Flush || w_stall;
  assign w_cnt_max = &r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_wr_addr    <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
      r_valid      <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      // Operand fields load even for a bubble; only control and valid are squashed.
      r_rs_addr <= bus.ID_RSaddr;
      r_rt_addr <= bus.ID_RTaddr;
      r_wr_addr <= bus.ID_RegDst ? bus.ID_RDaddr : bus.ID_RTaddr;
      r_rs_data <= bus.ID_RSdata;
      r_rt_data <= bus.ID_RTdata;
      r_imm     <= bus.ID_Imm;
      if (w_bubble) begin
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_alu_src    <= 1'b0;
        r_alu_op     <= '0;
        r_valid      <= 1'b0;
      end else begin
        r_reg_write  <= bus.ID_RegWrite;
        r_mem_read   <= bus.ID_MemRead;
        r_mem_write  <= bus.ID_MemWrite;
        r_mem_to_reg <= bus.ID_MemtoReg;
        r_alu_src    <= bus.ID_ALUSrc;
        r_alu_op     <= bus.ID_ALUOp;
        r_valid      <= 1'b1;
      end
      if (w_stall && !w_cnt_max) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.EX_RSaddr   = r_rs_addr;
  assign bus.EX_RTaddr   = r_rt_addr;
  assign bus.EX_WRaddr   = r_wr_addr;
  assign bus.EX_RSdata   = r_rs_data;
  assign bus.EX_RTdata   = r_rt_data;
  assign bus.EX_Imm      = r_imm;
  assign bus.EX_RegWrite = r_reg_write;
  assign bus.EX_MemRead  = r_mem_read;
  assign bus.EX_MemWrite = r_mem_write;
  assign bus.EX_MemtoReg = r_mem_to_reg;
  assign bus.EX_ALUSrc   = r_alu_src;
  assign bus.EX_ALUOp    = r_alu_op;
  assign bus.EX_Valid    = r_valid;
  assign bus.Stall       = w_stall;
  assign bus.PC_Write    = !w_stall;
  assign bus.IFID_Write  = !w_stall;
  assign bus.StallCnt    = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed hazard cases then random traffic against a transaction-level model.
// A second instance with a 2-bit counter runs on the same stimulus to exercise saturation.
module tb_id_ex_hazard_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_hazard_if #(.CNT_W(16)) bw();
  id_ex_hazard_if #(.CNT_W(2))  bn();

  id_ex_hazard_reg #(.CNT_W(16)) dut_w (.clk_i(clk), .rst_i(rst), .bus(bw.slave));
  id_ex_hazard_reg #(.CNT_W(2))  dut_n (.clk_i(clk), .rst_i(rst), .bus(bn.slave));

  assign bn.ID_RSaddr   = bw.ID_RSaddr;
  assign bn.ID_RTaddr   = bw.ID_RTaddr;
  assign bn.ID_RDaddr   = bw.ID_RDaddr;
  assign bn.ID_UseRT    = bw.ID_UseRT;
  assign bn.ID_RSdata   = bw.ID_RSdata;
  assign bn.ID_RTdata   = bw.ID_RTdata;
  assign bn.ID_Imm      = bw.ID_Imm;
  assign bn.ID_RegWrite = bw.ID_RegWrite;
  assign bn.ID_MemRead  = bw.ID_MemRead;
  assign bn.ID_MemWrite = bw.ID_MemWrite;
  assign bn.ID_MemtoReg = bw.ID_MemtoReg;
  assign bn.ID_ALUSrc   = bw.ID_ALUSrc;
  assign bn.ID_RegDst   = bw.ID_RegDst;
  assign bn.ID_ALUOp    = bw.ID_ALUOp;
  assign bn.Flush       = bw.Flush;

  int n_chk = 0;
  int n_fail = 0;

  // What sits in EX, as an instruction record; "known" means the operand fields are meaningful.
  typedef struct {
    bit          valid;
    bit          known;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rsd, rtd, imm;
    bit          regw, memrd, memwr, m2r, asrc;
    logic [2:0]  op;
  } ex_t;

  ex_t         m;
  int unsigned m_stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned n, input int w);
    int unsigned top;
    top = (32'd1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  // Stall when EX holds a real load whose nonzero destination is among the registers ID reads.
  function automatic bit model_stall();
    logic [4:0] reads[$];
    reads.push_back(bw.ID_RSaddr);
    if (bw.ID_UseRT) reads.push_back(bw.ID_RTaddr);
    if (!(m.valid && m.memrd) || m.dest == 5'd0) return 1'b0;
    foreach (reads[i]) if (reads[i] == m.dest) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_ex();
    logic [8:0] ctl_exp;
    ctl_exp = {m.valid, m.regw, m.memrd, m.memwr, m.m2r, m.asrc, m.op};
    chk("ex_valid",   bw.EX_Valid,    m.valid);
    chk("ex_regwrite",bw.EX_RegWrite, m.regw);
    chk("ex_memread", bw.EX_MemRead,  m.memrd);
    chk("ex_memwrite",bw.EX_MemWrite, m.memwr);
    chk("ex_memtoreg",bw.EX_MemtoReg, m.m2r);
    chk("ex_alusrc",  bw.EX_ALUSrc,   m.asrc);
    chk("ex_aluop",   bw.EX_ALUOp,    m.op);
    chk("n_ctl", {bn.EX_Valid, bn.EX_RegWrite, bn.EX_MemRead, bn.EX_MemWrite,
                  bn.EX_MemtoReg, bn.EX_ALUSrc, bn.EX_ALUOp}, ctl_exp);
    chk("cnt_w", bw.StallCnt, sat(m_stalls, 16));
    chk("cnt_n", bn.StallCnt, sat(m_stalls, 2));
    if (m.known) begin
      chk("ex_rsaddr", bw.EX_RSaddr, m.rs);
      chk("ex_rtaddr", bw.EX_RTaddr, m.rt);
      chk("ex_wraddr", bw.EX_WRaddr, m.dest);
      chk("ex_rsdata", bw.EX_RSdata, m.rsd);
      chk("ex_rtdata", bw.EX_RTdata, m.rtd);
      chk("ex_imm",    bw.EX_Imm,    m.imm);
      chk("n_addr", {bn.EX_RSaddr, bn.EX_RTaddr, bn.EX_WRaddr}, {m.rs, m.rt, m.dest});
      chk("n_rsdata", bn.EX_RSdata, m.rsd);
      chk("n_rtdata", bn.EX_RTdata, m.rtd);
      chk("n_imm",    bn.EX_Imm,    m.imm);
    end
  endtask

  // One clock: check hazard outputs mid-cycle, advance the model, check EX just after the edge.
  task automatic cycle(input bit r);
    bit st;
    rst = r;
    @(negedge clk);
    st = model_stall();
    chk("stall",      bw.Stall,      st);
    chk("pc_write",   bw.PC_Write,   !st);
    chk("ifid_write", bw.IFID_Write, !st);
    chk("n_hazard", {bn.Stall, bn.PC_Write, bn.IFID_Write}, {st, !st, !st});
    if (r) begin
      m = '{default: 0};
      m.known = 1'b1;
      m_stalls = 0;
    end else begin
      if (st) m_stalls++;
      if (bw.Flush || st) begin
        m = '{default: 0};
      end else begin
        m.valid = 1'b1;
        m.known = 1'b1;
        m.rs    = bw.ID_RSaddr;
        m.rt    = bw.ID_RTaddr;
        m.dest  = bw.ID_RegDst ? bw.ID_RDaddr : bw.ID_RTaddr;
        m.rsd   = bw.ID_RSdata;
        m.rtd   = bw.ID_RTdata;
        m.imm   = bw.ID_Imm;
        m.regw  = bw.ID_RegWrite;
        m.memrd = bw.ID_MemRead;
        m.memwr = bw.ID_MemWrite;
        m.m2r   = bw.ID_MemtoReg;
        m.asrc  = bw.ID_ALUSrc;
        m.op    = bw.ID_ALUOp;
      end
    end
    @(posedge clk);
    #1;
    check_ex();
  endtask

  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 0) ? 5'd0 : 5'(7 + k);
  endfunction

  task automatic rand_id(input bit allow_flush);
    bw.ID_RSaddr   = pick_reg();
    bw.ID_RTaddr   = pick_reg();
    bw.ID_RDaddr   = pick_reg();
    bw.ID_UseRT    = 1'($urandom);
    bw.ID_RSdata   = $urandom;
    bw.ID_RTdata   = $urandom;
    bw.ID_Imm      = $urandom;
    bw.ID_RegWrite = 1'($urandom);
    bw.ID_MemRead  = ($urandom_range(0, 2) != 0);
    bw.ID_MemWrite = 1'($urandom);
    bw.ID_MemtoReg = 1'($urandom);
    bw.ID_ALUSrc   = 1'($urandom);
    bw.ID_RegDst   = 1'($urandom);
    bw.ID_ALUOp    = 3'($urandom);
    bw.Flush       = allow_flush && ($urandom_range(0, 9) == 0);
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input bit use_rt, input bit reg_dst, input bit reg_write,
                        input bit mem_read, input bit mem_write, input bit flush);
    rand_id(1'b0);
    bw.ID_RSaddr   = rs;
    bw.ID_RTaddr   = rt;
    bw.ID_RDaddr   = rd;
    bw.ID_UseRT    = use_rt;
    bw.ID_RegDst   = reg_dst;
    bw.ID_RegWrite = reg_write;
    bw.ID_MemRead  = mem_read;
    bw.ID_MemWrite = mem_write;
    bw.ID_MemtoReg = mem_read;
    bw.Flush       = flush;
  endtask

  task automatic load_r9();
    set_id(5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned sat_exp[4];
    sat_exp = '{1, 2, 3, 3};
    m = '{default: 0};
    m_stalls = 0;

    rand_id(1'b1);
    @(posedge clk);
    #1;
    cycle(1'b1);
    rand_id(1'b1);
    cycle(1'b1);
    chk("rst_valid", bw.EX_Valid, 1'b0);
    chk("rst_pcw",   bw.PC_Write, 1'b1);
    chk("rst_cnt",   bw.StallCnt, 0);

    set_id(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0);
    chk("pt_wraddr", bw.EX_WRaddr, 5'd10);
    chk("pt_valid",  bw.EX_Valid,  1'b1);

    load_r9();
    cycle(1'b0);
    set_id(5'd9, 5'd3, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_stall", bw.Stall,      1'b1);
    chk("lu_pcw",   bw.PC_Write,   1'b0);
    chk("lu_ifid",  bw.IFID_Write, 1'b0);
    cycle(1'b0);
    chk("lu_bubble", {bw.EX_Valid, bw.EX_RegWrite}, 2'b00);
    chk("lu_cnt",    bw.StallCnt, 1);
    chk("lu_clear",  bw.Stall,    1'b0);
    cycle(1'b0);

    load_r9();
    cycle(1'b0);
    set_id(5'd4, 5'd9, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rt_unused_nostall", bw.Stall, 1'b0);
    cycle(1'b0);

    set_id(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0);
    set_id(5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("r0_nostall", bw.Stall, 1'b0);
    cycle(1'b0);

    load_r9();
    cycle(1'b0);
    set_id(5'd4, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("sw_stall", bw.Stall, 1'b1);
    cycle(1'b0);

    load_r9();
    cycle(1'b0);
    set_id(5'd9, 5'd5, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("fs_stall", bw.Stall, 1'b1);
    cycle(1'b0);
    chk("fs_bubble", bw.EX_Valid, 1'b0);
    chk("fs_cnt",    bw.StallCnt, 3);

    set_id(5'd6, 5'd7, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("fl_pcw", bw.PC_Write, 1'b1);
    cycle(1'b0);
    chk("fl_bubble", bw.EX_Valid, 1'b0);

    rand_id(1'b0);
    cycle(1'b1);
    for (int k = 0; k < 4; k++) begin
      load_r9();
      cycle(1'b0);
      set_id(5'd9, 5'd2, 5'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0);
      chk("sat_cnt_n", bn.StallCnt, sat_exp[k]);
      chk("sat_cnt_w", bw.StallCnt, k + 1);
      cycle(1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      rand_id(1'b1);
      cycle($urandom_range(0, 32) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
